kernel_line_buffer: RTL



---
 rtl/conv_pkg.sv | 16 +
 rtl/kernel_line_buffer_if.sv | 25 ++
 rtl/line_ram.sv | 29 ++
 rtl/pipeline.sv | 30 +++
 rtl/kernel_line_buffer.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution path: RGB565 pixels, kernel columns
// and the row-RAM rotation helper used by the line buffer.
package conv_pkg;

    localparam int KERNEL_SIZE   = 3;
    localparam int NUM_LINE_RAMS = 4;

    typedef logic [15:0] pixel_t;
    typedef pixel_t [KERNEL_SIZE-1:0] column_t;

    // Row RAMs rotate modulo 4, so the 2-bit sum wraps naturally.
    function automatic logic [1:0] ram_sel(input logic [1:0] base, input logic [1:0] offs);
        return base + offs;
    endfunction

endpackage

// File: rtl/kernel_line_buffer_if.sv
// Pixel-stream in / kernel-column out bundle of the line buffer.
// master = pixel source side, slave = line buffer side.
interface kernel_line_buffer_if;
    import conv_pkg::*;

    pixel_t      data_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        data_valid_in;
    column_t     line_buffer_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        data_valid_out;

    modport master (
        output data_in, hcount_in, vcount_in, data_valid_in,
        input  line_buffer_out, hcount_out, vcount_out, data_valid_out
    );

    modport slave (
        input  data_in, hcount_in, vcount_in, data_valid_in,
        output line_buffer_out, hcount_out, vcount_out, data_valid_out
    );

endinterface

// File: rtl/line_ram.sv
// Single-row pixel RAM: simple dual port, one clock, registered read-first output.
module line_ram
    import conv_pkg::*;
#(
    parameter int DEPTH = 1280,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  pixel_t        wdata_i,
    input  logic [AW-1:0] raddr_i,
    output pixel_t        rdata_o
);

    pixel_t mem_q [DEPTH];
    pixel_t rdata_q;

    // Write port plus registered read; NBA ordering gives old data on same-address access.
    always_ff @(posedge clk_in) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pipeline.sv
// Generic fixed-latency delay line with synchronous active-high clear.
module pipeline #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift register, cleared as a whole on reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[STAGES-1];

endmodule

// File: rtl/kernel_line_buffer.sv
// Four rotating row RAMs turning a raster pixel stream into 3-pixel vertical columns.
// Optional KERNEL_LINE_BUFFER_EDGE_REPLICATE_EN replicates the center row at frame edges.
module kernel_line_buffer
    import conv_pkg::*;
#(
    parameter int HRES = 1280,
    parameter int VRES = 720
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    kernel_line_buffer_if.slave  bus
);

    localparam int          AW        = $clog2(HRES);
    localparam int          PW        = 11 + 10 + 1;
    localparam logic [10:0] HRES_LAST = 11'(HRES - 1);
    localparam logic [9:0]  VRES_M2   = 10'(VRES - 2);
    localparam logic [9:0]  VRES_M1   = 10'(VRES - 1);

    logic [1:0]    wr_sel_q;
    logic [1:0]    wr_sel_d;
    logic [1:0]    rd_base_q;
    logic          in_range_s;
    logic          we_s;
    logic [AW-1:0] addr_s;
    logic [9:0]    vc_adj_s;
    pixel_t        rdata_s [NUM_LINE_RAMS];
    column_t       raw_s;
    column_t       col_d;
    column_t       col_q;
    logic [PW-1:0] pipe_in_s;
    logic [PW-1:0] pipe_out_s;

    // Reset wins over a same-edge pixel: no write and no row advance.
    assign in_range_s = (bus.hcount_in <= HRES_LAST);
    assign we_s       = bus.data_valid_in && in_range_s && !rst_in;
    assign addr_s     = bus.hcount_in[AW-1:0];

    // Row advance on the last accepted pixel of a row.
    always_comb begin
        wr_sel_d = wr_sel_q;
        if (we_s && (bus.hcount_in == HRES_LAST)) begin
            wr_sel_d = wr_sel_q + 2'd1;
        end else begin
            wr_sel_d = wr_sel_q;
        end
    end

    // Center row of the emitted column is two rows above the incoming one.
    always_comb begin
        vc_adj_s = 10'd0;
        if (bus.vcount_in >= 10'd2) begin
            vc_adj_s = bus.vcount_in - 10'd2;
        end else begin
            vc_adj_s = bus.vcount_in + VRES_M2;
        end
    end

    for (genvar g = 0; g < NUM_LINE_RAMS; g++) begin : g_ram
        line_ram #(
            .DEPTH (HRES),
            .AW    (AW)
        ) u_ram (
            .clk_in  (clk_in),
            .we_i    (we_s && (wr_sel_q == 2'(g))),
            .waddr_i (addr_s),
            .wdata_i (bus.data_in),
            .raddr_i (addr_s),
            .rdata_o (rdata_s[g])
        );
    end

    // Write pointer plus the pointer value matching the RAM read register stage.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_sel_q  <= 2'd0;
            rd_base_q <= 2'd0;
        end else begin
            wr_sel_q  <= wr_sel_d;
            rd_base_q <= wr_sel_q;
        end
    end

    // RAMs after the one being written hold rows v-3, v-2, v-1 in order.
    always_comb begin
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            raw_s[k] = rdata_s[ram_sel(rd_base_q, 2'(k + 1))];
        end
    end

`ifdef KERNEL_LINE_BUFFER_EDGE_REPLICATE_EN
    logic [9:0] vc1_q;

    // Center-row number at the RAM read stage, used to spot frame edges.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vc1_q <= 10'd0;
        end else begin
            vc1_q <= vc_adj_s;
        end
    end

    // Replace the out-of-frame neighbour row with the center row.
    always_comb begin
        col_d    = raw_s;
        col_d[0] = (vc1_q == 10'd0)    ? raw_s[1] : raw_s[0];
        col_d[2] = (vc1_q == VRES_M1)  ? raw_s[1] : raw_s[2];
    end
`else
    // Raw RAM contents pass through unmodified.
    always_comb begin
        col_d = raw_s;
    end
`endif

    // Output column register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    assign pipe_in_s = {bus.hcount_in, vc_adj_s, bus.data_valid_in};

    pipeline #(
        .WIDTH  (PW),
        .STAGES (2)
    ) u_pipe (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .data_i (pipe_in_s),
        .data_o (pipe_out_s)
    );

    assign bus.line_buffer_out = col_q;
    assign bus.hcount_out      = pipe_out_s[PW-1 -: 11];
    assign bus.vcount_out      = pipe_out_s[10:1];
    assign bus.data_valid_out  = pipe_out_s[0];

endmodule
